// File: rtl/sram_2port_banked.sv
// sram_2port_banked: two-port RAM on banked 512x8 macros.
// Define SRAM2P_FIXED_PRIO_EN to make port A always win same-bank conflicts.

// Behavioural 512x8 macro: CEN enables, GWN writes, WEN masks bits.
module gf180mcu_fd_ip_sram__sram512x8m8wm1 (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  logic [7:0] r_mem [512];

  // Masked write, otherwise synchronous read into Q
  always_ff @(posedge CLK) begin
    if (CEN && GWN)
      r_mem[A] <= (r_mem[A] & ~WEN) | (D & WEN);
    else if (CEN)
      Q <= r_mem[A];
  end

endmodule

module sram_2port_banked #(
  parameter  int WIDTH     = 16,
  parameter  int WORDS     = 2048,
  localparam int ADDR_BITS = $clog2(WORDS),
  localparam int W         = (WIDTH + 7) / 8,
  localparam int H         = WORDS / 512
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [WIDTH-1:0]     a_wdata,
  input  logic [W-1:0]         a_be,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [WIDTH-1:0]     a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [WIDTH-1:0]     b_wdata,
  input  logic [W-1:0]         b_be,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [WIDTH-1:0]     b_rdata
);

  localparam int BB = (H > 1) ? $clog2(H) : 1;
  localparam int DW = 8 * W;
  localparam logic [7:0] TOP_WEN =
    (WIDTH % 8 == 0) ? 8'hFF : 8'((1 << (WIDTH % 8)) - 1);

  logic [BB-1:0]        w_a_bank;
  logic [BB-1:0]        w_b_bank;
  logic                 w_conflict;
  logic                 w_a_wins;
  logic [DW-1:0]        w_a_wd;
  logic [DW-1:0]        w_b_wd;
  logic [H-1:0][DW-1:0] w_q_all;
  logic [DW-1:0]        w_a_q;
  logic [DW-1:0]        w_b_q;

  logic                 r_a_rvalid;
  logic                 r_b_rvalid;
  logic [BB-1:0]        r_a_bank;
  logic [BB-1:0]        r_b_bank;

  assign w_a_bank = BB'(a_addr >> 9);
  assign w_b_bank = BB'(b_addr >> 9);
  assign w_a_wd   = DW'(a_wdata);
  assign w_b_wd   = DW'(b_wdata);

  assign w_conflict = a_req && b_req && (w_a_bank == w_b_bank);

`ifdef SRAM2P_FIXED_PRIO_EN
  assign w_a_wins = 1'b1;
`else
  // r_last_b=1: B won the last conflict, so A wins the next one
  logic r_last_b;

  // Toggle the round-robin pointer on every arbitrated conflict
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_last_b <= 1'b1;
    else if (w_conflict)
      r_last_b <= ~r_last_b;
  end

  assign w_a_wins = r_last_b;
`endif

  assign a_gnt = reset_n && a_req && (!w_conflict || w_a_wins);
  assign b_gnt = reset_n && b_req && (!w_conflict || !w_a_wins);

  for (genvar h = 0; h < H; h++) begin : g_bank
    logic          w_sel_a;
    logic          w_sel_b;
    logic          w_wr;
    logic [8:0]    w_addr;
    logic [DW-1:0] w_d;
    logic [W-1:0]  w_be;
    logic [DW-1:0] w_q;

    assign w_sel_a = a_gnt && (w_a_bank == BB'(h));
    assign w_sel_b = b_gnt && (w_b_bank == BB'(h));
    assign w_wr    = (w_sel_a && a_we) || (w_sel_b && b_we);
    assign w_addr  = w_sel_b ? b_addr[8:0] : a_addr[8:0];
    assign w_d     = w_sel_b ? w_b_wd : w_a_wd;
    assign w_be    = w_sel_b ? b_be : a_be;

    for (genvar x = 0; x < W; x++) begin : g_lane
      gf180mcu_fd_ip_sram__sram512x8m8wm1 u_mac (
        .CLK (clock),
        .CEN (1'b1),
        .GWN (w_wr && w_be[x]),
        .WEN ((x == W - 1) ? TOP_WEN : 8'hFF),
        .A   (w_addr),
        .D   (w_d[8*x +: 8]),
        .Q   (w_q[8*x +: 8])
      );
    end

    assign w_q_all[h] = w_q;
  end

  // Track each port's read in flight and the bank it targets
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_bank   <= '0;
      r_b_bank   <= '0;
    end else begin
      r_a_rvalid <= a_gnt && !a_we;
      r_b_rvalid <= b_gnt && !b_we;
      if (a_gnt) r_a_bank <= w_a_bank;
      if (b_gnt) r_b_bank <= w_b_bank;
    end
  end

  // Select the macro outputs of the bank recorded at grant time
  always_comb begin
    w_a_q = '0;
    w_b_q = '0;
    for (int h = 0; h < H; h++) begin
      if (r_a_bank == BB'(h)) w_a_q = w_q_all[h];
      if (r_b_bank == BB'(h)) w_b_q = w_q_all[h];
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rvalid ? w_a_q[WIDTH-1:0] : '0;
  assign b_rdata  = r_b_rvalid ? w_b_q[WIDTH-1:0] : '0;

endmodule

// File: doc/sram_2port_banked.md
# sram_2port_banked

Parametrised two-port memory built from banked gf180mcu_fd_ip_sram__sram512x8m8wm1 macros. It serves two independent requesters, port A (CPU side) and port B (PPU/DMA side), and gives each port byte-lane write enables and a req/gnt handshake. Accesses to different banks are served in the same cycle; same-bank collisions are arbitrated. It replaces the single-port, full-word-write RAM wrapper wherever two agents share one physical RAM.

## Interface
Parameters:
- WIDTH, 16: data width in bits, 1..64.
- WORDS, 2048: depth in words; must be a multiple of 512.
- ADDR_BITS, derived: $clog2(WORDS). Not overridable.
- W, derived: (WIDTH+7)/8, the number of byte lanes.
- H, derived: WORDS/512, the number of banks.

Ports:
- clock  in  1  single clock; every register and macro uses its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request.
- a_we  in  1  port A write (1) or read (0).
- a_addr  in  ADDR_BITS  port A word address.
- a_wdata  in  WIDTH  port A write data.
- a_be  in  W  port A byte-lane enables; bit i covers data bits [8i+7:8i].
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  WIDTH  port A read data.
- b_req, b_we, b_addr, b_wdata, b_be, b_gnt, b_rvalid, b_rdata: same widths and meanings for port B.

## Operation
- Bank index is addr[ADDR_BITS-1:9]; the address within a bank is addr[8:0].
- Handshake: a requester holds req/we/addr/wdata/be stable until it sees gnt=1. gnt is combinational from req, addr and the arbitration state. A transfer happens in every cycle where req=gnt=1.
- When only one port requests, it is granted.
- When both ports request different banks, both are granted in that cycle. Each bank macro set is driven by its own port's address and data.
- When both ports request the same bank, exactly one port is granted (see Configuration). The losing port keeps its request asserted.
- Round-robin state is a single bit, `last_winner`. It updates only on a same-bank conflict. The next conflict goes to the port that did not win the previous one. After reset, A wins the first conflict.
- Macro drive rules:
  - CEN is tied to 1.
  - A bank's lane-x macro gets GWN=1 when a granted write targets that bank and be[x]=1.
  - WEN is 8'hFF, except in the top lane when WIDTH%8≠0; there only the valid low bits are set.
  - Lanes of a write with be[x]=0 keep their stored contents.
- A write with be=0 is still granted and completes with no storage change.
- A granted read sets that port's rvalid at the next edge. rdata is the lane-concatenated macro Q of the bank recorded at grant time, truncated to WIDTH.
- Whenever rvalid=0, rdata is forced to 0.
- Writes never assert rvalid.
- Reads and writes by different ports to the same address cannot occur in the same cycle, because same-bank requests are serialised. A read issued after a write to the same address returns the new data.

## Timing
- Grant: same cycle as the request, zero latency.
- Read latency: rvalid and rdata are valid exactly one cycle after the granted cycle.
- Throughput: one access per port per cycle when there is no conflict. Under a sustained same-bank conflict the grants alternate A,B,A,B…, so each port gets 50%.
- Reset values: a_gnt=b_gnt=0 while reset_n=0; a_rvalid=b_rvalid=0; a_rdata=b_rdata=0; last_winner selects A next.
- Reset asserted mid-operation: any read in flight is dropped and no rvalid follows. Macro contents are undefined and not cleared. No GWN pulses while reset_n=0.
- Requests in the first cycle after reset deassertion are legal.

## Configuration
- SRAM2P_FIXED_PRIO_EN:
  - Defined: port A always wins same-bank conflicts, `last_winner` is not implemented, and port B can starve.
  - Undefined (default): round-robin arbitration as described above.

## Test plan
- Single-port write/read: A writes 0xBEEF to addr 0x005 with be=2'b11, then reads addr 0x005 → a_gnt=1 on both accesses; the cycle after the read, a_rvalid=1 and a_rdata=0xBEEF.
- Byte enables: preload 0x1234 at 0x010; A writes 0xABCD with be=2'b10; A reads 0x010 → 0xAB34. A write with be=2'b00 leaves the value unchanged.
- Parallel banks: A reads 0x003 (bank 0) while B writes 0x5555 to 0x603 (bank 3) in the same cycle → a_gnt=b_gnt=1; A's data appears next cycle; a later B read of 0x603 returns 0x5555.
- Conflict, round-robin: A and B hold requests to 0x100 and 0x1FF for 4 cycles → grant order A,B,A,B. With SRAM2P_FIXED_PRIO_EN defined → A,A,A,A and b_gnt stays 0.
- Reset mid-read: grant a B read, then pull reset_n low before the next edge → b_rvalid=0, b_rdata=0, no gnt during reset. After release, the first conflict goes to A.
- Odd width: WIDTH=12 with WORDS=512 → write 0xFFF with be=2'b11, read back 0xFFF; the top lane uses WEN=8'h0F.
